board_io_sequencer: RTL and testbench

Parametrised board front-end that replaces button-clocked operand capture with a single-clock, debounced, pulse-driven sequencer.
- Loads NUM_IN operand slots from switches in order, signals when the full operand set is ready, and cycles NUM_OUT result views.
- Drives the 7-segment data bus with a valid flag in the LSB.
- Sits between the board switches/buttons/display driver and the ALU/shift datapath instances.

---
 rtl/board_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/board_io_sequencer.sv | 130 +++++++++++++
 tb/tb_board_io_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared constants and helpers for the board I/O front-end.
package board_pkg;

    localparam logic [31:0] BLANK_DEF  = 32'h88888888;
    localparam int          DISP_VALID = 0;

    // Button slots in the debouncer bank
    localparam int BTN_LOAD = 0;
    localparam int BTN_ARM  = 1;
    localparam int BTN_VIEW = 2;
    localparam int BTN_CLR  = 3;
    localparam int NUM_BTN  = 4;

    function automatic int clog2_min1(input int v);
        int r;
        r = (v > 1) ? $clog2(v) : 1;
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, registered rising-edge pulse.
module btn_debounce
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = clog2_min1(DEBOUNCE_CYC);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
            // Level flips only after DEBOUNCE_CYC back-to-back disagreeing samples
            if (r_sync2 != r_level) begin
                if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_pulse;

endmodule

// File: rtl/board_io_sequencer.sv
// Board front-end: debounced buttons drive operand loading, result viewing and clear.
module board_io_sequencer
    import board_pkg::*;
#(
    parameter int              DATA_W       = 32,
    parameter int              NUM_IN       = 3,
    parameter int              NUM_OUT      = 2,
    parameter int              DEBOUNCE_CYC = 1000000,
    parameter logic [DATA_W-1:0] BLANK      = DATA_W'(BLANK_DEF),
    localparam int             LPW          = clog2_min1(NUM_IN),
    localparam int             VPW          = clog2_min1(NUM_OUT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         sw,
    input  logic                      btn_load,
    input  logic                      btn_arm,
    input  logic                      btn_view,
    input  logic                      btn_clr,
    input  logic [NUM_OUT*DATA_W-1:0] results,
    output logic [NUM_IN*DATA_W-1:0]  operands,
    output logic                      operands_valid,
    output logic                      loaded,
    output logic [LPW-1:0]            load_ptr,
    output logic [VPW-1:0]            view_ptr,
    output logic [DATA_W:0]           disp_data
);

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_lvl;
    logic [NUM_BTN-1:0] w_rise;

    assign w_raw[BTN_LOAD] = btn_load;
    assign w_raw[BTN_ARM]  = btn_arm;
    assign w_raw[BTN_VIEW] = btn_view;
    assign w_raw[BTN_CLR]  = btn_clr;

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (w_raw[b]),
            .level      (w_lvl[b]),
            .rise_pulse (w_rise[b])
        );
    end

    // Only the arm level and the other buttons' pulses are consumed
    logic w_unused;
    assign w_unused = &{1'b0, w_lvl[BTN_LOAD], w_lvl[BTN_VIEW], w_lvl[BTN_CLR], w_rise[BTN_ARM]};

    logic w_load;
    logic w_view;
    logic w_clr;

    assign w_load = w_rise[BTN_LOAD] & w_lvl[BTN_ARM];
    assign w_view = w_rise[BTN_VIEW];
    assign w_clr  = w_rise[BTN_CLR];

    logic [NUM_IN-1:0][DATA_W-1:0] r_ops;
    logic                          r_ops_valid;
    logic                          r_loaded;
    logic [LPW-1:0]                r_load_ptr;
    logic [VPW-1:0]                r_view_ptr;
    logic [DATA_W:0]               r_disp;

    // Selected result word; index NUM_OUT falls through to the blank view
    logic [DATA_W-1:0] w_view_word;
    logic              w_view_hit;

    always_comb begin
        w_view_word = BLANK;
        w_view_hit  = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (r_view_ptr == VPW'(k)) begin
                w_view_word = results[k*DATA_W +: DATA_W];
                w_view_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops       <= '0;
            r_ops_valid <= 1'b0;
            r_loaded    <= 1'b0;
            r_load_ptr  <= '0;
            r_view_ptr  <= '0;
            r_disp      <= {BLANK, 1'b0};
        end else begin
            r_ops_valid <= 1'b0;
            if (w_clr) begin
                r_ops      <= '0;
                r_loaded   <= 1'b0;
                r_load_ptr <= '0;
                r_view_ptr <= '0;
                r_disp     <= {BLANK, 1'b0};
            end else begin
                if (w_load) begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (r_load_ptr == LPW'(i)) r_ops[i] <= sw;
                    end
                    if (r_load_ptr == '0) r_loaded <= 1'b0;
                    if (r_load_ptr == LPW'(NUM_IN - 1)) begin
                        r_load_ptr  <= '0;
                        r_ops_valid <= 1'b1;
                        r_loaded    <= 1'b1;
                    end else begin
                        r_load_ptr <= r_load_ptr + 1'b1;
                    end
                end
                // A same-cycle view owns the display; the load still updates its slot
                if (w_view) begin
                    r_disp     <= {w_view_word, w_view_hit};
                    r_view_ptr <= (r_view_ptr == VPW'(NUM_OUT)) ? '0 : r_view_ptr + 1'b1;
                end else if (w_load) begin
                    r_disp <= {sw, 1'b1};
                end
            end
        end
    end

    assign operands       = r_ops;
    assign operands_valid = r_ops_valid;
    assign loaded         = r_loaded;
    assign load_ptr       = r_load_ptr;
    assign view_ptr       = r_view_ptr;
    assign disp_data      = r_disp;

endmodule

// File: tb/tb_board_io_sequencer.sv
// Directed vector bench for board_io_sequencer with a short debounce window.
module tb_board_io_sequencer;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] sw = '0;
    logic          btn_load = 1'b0;
    logic          btn_arm = 1'b0;
    logic          btn_view = 1'b0;
    logic          btn_clr = 1'b0;
    logic [63:0]   results = {32'h0000000F, 32'h00000008};
    logic [95:0]   operands;
    logic          operands_valid;
    logic          loaded;
    logic [1:0]    load_ptr;
    logic [1:0]    view_ptr;
    logic [32:0]   disp_data;

    board_io_sequencer #(
        .DATA_W(32), .NUM_IN(3), .NUM_OUT(2), .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .btn_load(btn_load), .btn_arm(btn_arm), .btn_view(btn_view), .btn_clr(btn_clr),
        .results(results), .operands(operands), .operands_valid(operands_valid),
        .loaded(loaded), .load_ptr(load_ptr), .view_ptr(view_ptr), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    int vcnt = 0;

    always @(negedge clk) if (operands_valid) vcnt++;

    localparam logic [32:0] BLANK_D = {32'h88888888, 1'b0};

    typedef struct {
        logic        arm, ld, vw, cl;
        logic [31:0] sw;
        logic [32:0] disp;
        logic [1:0]  lp, vp;
        logic        loaded;
        int          vcnt;
        logic [95:0] ops;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input logic l, input logic v, input logic c, input logic [31:0] s);
        sw = s;
        @(posedge clk); #1;
        btn_load = l; btn_view = v; btn_clr = c;
        repeat (12) @(posedge clk);
        #1;
        btn_load = 1'b0; btn_view = 1'b0; btn_clr = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic set_arm(input logic a);
        if (btn_arm !== a) begin
            btn_arm = a;
            repeat (12) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //            arm   ld    vw    cl    sw            disp                  lp vp ld vc ops
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h5,        {32'h5, 1'b1},        1, 0, 0, 0, {32'h0, 32'h0, 32'h5}};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hA,        {32'hA, 1'b1},        2, 0, 0, 0, {32'h0, 32'hA, 32'h5}};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h3,        {32'h3, 1'b1},        0, 0, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, {32'h3, 1'b1},        0, 0, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        {32'h8, 1'b1},        0, 1, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        {32'hF, 1'b1},        0, 2, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        BLANK_D,              0, 0, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        {32'h8, 1'b1},        0, 1, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        {32'hF, 1'b1},        0, 2, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        BLANK_D,              0, 0, 1, 1, {32'h3, 32'hA, 32'h5}};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h7,        {32'h8, 1'b1},        1, 1, 0, 1, {32'h3, 32'hA, 32'h7}};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h9,        BLANK_D,              0, 0, 0, 1, 96'h0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst disp", disp_data, BLANK_D);
        chk("rst ops", operands, 96'h0);
        chk("rst ptrs", {load_ptr, view_ptr, loaded, operands_valid}, 6'h0);
        @(negedge clk) rst_n = 1'b1;
        set_arm(1'b1);

        for (int i = 0; i < 12; i++) begin
            set_arm(vecs[i].arm);
            press(vecs[i].ld, vecs[i].vw, vecs[i].cl, vecs[i].sw);
            chk($sformatf("v%0d disp", i), disp_data, vecs[i].disp);
            chk($sformatf("v%0d load_ptr", i), load_ptr, vecs[i].lp);
            chk($sformatf("v%0d view_ptr", i), view_ptr, vecs[i].vp);
            chk($sformatf("v%0d loaded", i), loaded, vecs[i].loaded);
            chk($sformatf("v%0d valid_cnt", i), vcnt, vecs[i].vcnt);
            chk($sformatf("v%0d ops", i), operands, vecs[i].ops);
        end

        // Results are captured at the view pulse only
        press(1'b0, 1'b1, 1'b0, 32'h0);
        chk("view sample", disp_data, {32'h8, 1'b1});
        results[31:0] = 32'h55;
        repeat (5) @(posedge clk);
        #1;
        chk("view no track", disp_data, {32'h8, 1'b1});
        results[31:0] = 32'h8;

        // 3-cycle glitch must not produce a load
        sw = 32'h11;
        @(posedge clk); #1;
        btn_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        btn_load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("glitch lp", load_ptr, 2'd0);
        chk("glitch disp", disp_data, {32'h8, 1'b1});

        // Clean hold: pulse after edge 7, sequencer acts on edge 8
        sw = 32'h22;
        @(posedge clk); #1;
        btn_load = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("lat pre lp", load_ptr, 2'd0);
        @(posedge clk); #1;
        chk("lat post lp", load_ptr, 2'd1);
        chk("lat post disp", disp_data, {32'h22, 1'b1});
        repeat (2) @(posedge clk);
        #1;
        btn_load = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("hold single", load_ptr, 2'd1);

        // Async reset mid-sequence discards the partial load
        press(1'b1, 1'b0, 1'b0, 32'h33);
        chk("pre rst lp", load_ptr, 2'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("async disp", disp_data, BLANK_D);
        chk("async ops", operands, 96'h0);
        chk("async ptrs", {load_ptr, view_ptr, loaded, operands_valid}, 6'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        press(1'b1, 1'b0, 1'b0, 32'h4);
        chk("rl1 ops", operands, {32'h0, 32'h0, 32'h4});
        press(1'b1, 1'b0, 1'b0, 32'h5);
        chk("rl2 vcnt", vcnt, 1);
        press(1'b1, 1'b0, 1'b0, 32'h6);
        chk("rl3 vcnt", vcnt, 2);
        chk("rl3 ops", operands, {32'h6, 32'h5, 32'h4});
        chk("rl3 state", {load_ptr, loaded}, {2'd0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
